fmap_collector: RTL and testbench
=================================

Name: fmap_collector

Overview:
- Receiving end of the accelerator's result stream. Sinks the row-major `dout`/`valid_out` pooled feature-map stream from the CNN top.
- Places each sample at its (row, col) slot in an internal frame buffer and flags frame completion.
- Exposes a registered random-access read port so the host/DMA can read back the finished feature map.
- Replaces bench-side matrix capture with synthesizable collection logic.

Parameters:
- DATA_W, 8, sample width (signed two's complement).
- MAX_DIM, 16, maximum feature-map width/height.
- DEPTH, MAX_DIM*MAX_DIM, frame buffer entries.
- ADDR_W, 8, read address / count width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle pulse: latch dims, arm a new frame.
- fm_width, input, 8, feature-map width (columns).
- fm_height, input, 8, feature-map height (rows).
- valid_in, input, 1, `din` qualifier; connects to the accelerator's `valid_out`.
- din, input, DATA_W, signed sample; connects to the accelerator's `dout`.
- busy, output, 1, high in COLLECT.
- frame_done, output, 1, high in DONE.
- overflow, output, 1, sticky: `valid_in` seen outside COLLECT.
- cfg_err, output, 1, sticky: last `start` had illegal dims.
- sample_count, output, ADDR_W+1, samples written this frame.
- cur_row, output, 8, row index of next write.
- cur_col, output, 8, column index of next write.
- rd_en, input, 1, read request.
- rd_addr, input, ADDR_W, linear address, row*fm_width+col.
- rd_data, output, DATA_W, read data.
- rd_valid, output, 1, `rd_data` valid.

Behaviour:
- Reset values (async on `rst`):
  - state=IDLE.
  - `busy`, `frame_done`, `overflow`, `cfg_err`, `rd_valid` = 0.
  - `rd_data`, `sample_count`, `cur_row`, `cur_col` = 0.
  - Buffer contents not reset.
- FSM states: IDLE, COLLECT, DONE.
- `start` in any state:
  - If `fm_width`==0, `fm_height`==0, `fm_width`>MAX_DIM, or `fm_height`>MAX_DIM: set `cfg_err`, go to IDLE, leave `overflow` unchanged.
  - Otherwise: latch dims, clear `cfg_err`, `overflow`, `sample_count`, `cur_row`, `cur_col`, go to COLLECT.
  - `start` in COLLECT aborts the current frame; the partial data remains in the buffer.
- COLLECT, `valid_in`=1:
  - Write `din` to mem[cur_row*W+cur_col]; `sample_count`+1.
  - `cur_col`+1; at `cur_col`==W-1, wrap `cur_col` to 0 and `cur_row`+1.
  - On the write of sample W*H: next state DONE; `cur_row`/`cur_col` hold at 0/0.
  - One write per cycle, no backpressure; accepts `valid_in` every cycle.
- Simultaneous `start` and `valid_in`: `start` wins; the sample is dropped and no flag is set.
- IDLE or DONE, `valid_in`=1: sample dropped, buffer untouched, `overflow` set.
- DONE holds until the next `start` or `rst`.
- Address arithmetic: `cur_row`*W+`cur_col` is computed unsigned at ADDR_W bits and never exceeds DEPTH-1.
- Read port:
  - Latency 1: `rd_en` at cycle N gives `rd_data`/`rd_valid` at N+1.
  - `rd_valid` = registered `rd_en`.
  - Reads legal in every state.
  - `rd_addr` >= DEPTH returns 0.
  - Read and write to the same address in the same cycle return the old data (read-before-write).
  - `rd_data` holds its value when `rd_en`=0.
- Reset mid-frame: immediate return to IDLE. A frame in progress is lost; the host must re-issue `start`.

Optional Feature:
- Macro: FMAP_UINT8_OUT_EN.
- Defined: read data is converted back to pixel range. `rd_data` = `mem` + 128 (mod 256), i.e. MSB inverted, presented unsigned; -128→0, 0→128, 127→255.
- Undefined: `rd_data` is the raw signed stored value.
- Storage and all write-side behaviour are identical either way.

Test Plan:
- 6x6 frame, bursty input:
  - Stimulus: `start` with W=H=6; stream 36 samples din=k-18 (k=0..35) with valid_in bursty (3 on, 1 off).
  - Response: `frame_done`=1 the cycle after sample 36, `sample_count`=36, `busy`=0.
  - Readback of addr 0/35 gives -18/17; with FMAP_UINT8_OUT_EN, 110/145.
- Back-to-back wrap:
  - Stimulus: W=3, H=2, six samples back-to-back.
  - Response: `cur_col` sequence 0,1,2,0,1,2; `cur_row` goes to 1 after the 3rd sample; addr 4 holds the 5th sample.
- Illegal configuration:
  - Stimulus: `start` with W=0; then `start` with W=17, H=4.
  - Response: `cfg_err`=1 after each, state stays IDLE.
  - A subsequent valid `start` (4x4) clears `cfg_err`.
- Overflow:
  - Stimulus: a 37th sample after a 6x6 frame completes.
  - Response: `overflow`=1, addr 0 unchanged; the next `start` clears `overflow`.
- Abort, simultaneous events, reset:
  - `start` asserted with `valid_in` on sample 10: sample dropped, `sample_count`=0, `busy`=1.
  - Assert `rst` mid-frame: all outputs return to reset values within the same cycle.
- Read hazard:
  - Stimulus: `rd_en` at addr 5 in the same cycle the collector writes addr 5 (din=42, old value -7).
  - Response: `rd_data`=-7 next cycle; a reread gives 42; `rd_addr`=300 gives 0.

Source files
------------

// File: rtl/fmap_collector_if.sv
// Bus bundle for fmap_collector: frame control, result stream in, status out, and the read-back port.
interface fmap_collector_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic                     start;
  logic [7:0]               fm_width;
  logic [7:0]               fm_height;
  logic                     valid_in;
  logic signed [DATA_W-1:0] din;
  logic                     busy;
  logic                     frame_done;
  logic                     overflow;
  logic                     cfg_err;
  logic [ADDR_W:0]          sample_count;
  logic [7:0]               cur_row;
  logic [7:0]               cur_col;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_valid;

  modport master (
    output start, fm_width, fm_height, valid_in, din, rd_en, rd_addr,
    input  busy, frame_done, overflow, cfg_err, sample_count, cur_row, cur_col, rd_data, rd_valid
  );

  modport slave (
    input  start, fm_width, fm_height, valid_in, din, rd_en, rd_addr,
    output busy, frame_done, overflow, cfg_err, sample_count, cur_row, cur_col, rd_data, rd_valid
  );
endinterface

// File: rtl/fmap_collector.sv
// Collects the row-major pooled feature-map stream into a frame buffer with a 1-cycle read port.
// Define FMAP_UINT8_OUT_EN to present read data offset by +128 (unsigned pixel range).
module fmap_collector #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 16,
  parameter int DEPTH   = MAX_DIM * MAX_DIM,
  parameter int ADDR_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  fmap_collector_if.slave bus
);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        width_q, width_d;
  logic [7:0]        height_q, height_d;
  logic              overflow_q, overflow_d;
  logic              cfg_err_q, cfg_err_d;
  logic [ADDR_W:0]   sample_count_q, sample_count_d;
  logic [7:0]        cur_row_q, cur_row_d;
  logic [7:0]        cur_col_q, cur_col_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              dims_ok_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [ADDR_W:0]   count_next_s;
  logic [31:0]       frame_total_s;

  function automatic logic [DATA_W-1:0] rd_format(input logic [DATA_W-1:0] raw);
`ifdef FMAP_UINT8_OUT_EN
    rd_format = {~raw[DATA_W-1], raw[DATA_W-2:0]};
`else
    rd_format = raw;
`endif
  endfunction

  assign dims_ok_s     = (bus.fm_width != 8'd0) && (bus.fm_height != 8'd0) &&
                         (bus.fm_width <= 8'(MAX_DIM)) && (bus.fm_height <= 8'(MAX_DIM));
  assign wr_addr_s     = ADDR_W'(32'(cur_row_q) * 32'(width_q) + 32'(cur_col_q));
  assign count_next_s  = sample_count_q + (ADDR_W+1)'(1);
  assign frame_total_s = 32'(width_q) * 32'(height_q);

  // Frame control: start wins over a coincident sample; stray samples only raise overflow.
  always_comb begin
    state_d        = state_q;
    width_d        = width_q;
    height_d       = height_q;
    overflow_d     = overflow_q;
    cfg_err_d      = cfg_err_q;
    sample_count_d = sample_count_q;
    cur_row_d      = cur_row_q;
    cur_col_d      = cur_col_q;
    wr_en_s        = 1'b0;
    if (bus.start) begin
      if (dims_ok_s) begin
        width_d        = bus.fm_width;
        height_d       = bus.fm_height;
        cfg_err_d      = 1'b0;
        overflow_d     = 1'b0;
        sample_count_d = '0;
        cur_row_d      = 8'd0;
        cur_col_d      = 8'd0;
        state_d        = ST_COLLECT;
      end else begin
        cfg_err_d = 1'b1;
        state_d   = ST_IDLE;
      end
    end else if (bus.valid_in) begin
      case (state_q)
        ST_COLLECT: begin
          wr_en_s        = 1'b1;
          sample_count_d = count_next_s;
          if (32'(count_next_s) == frame_total_s) begin
            state_d   = ST_DONE;
            cur_row_d = 8'd0;
            cur_col_d = 8'd0;
          end else if (cur_col_q == width_q - 8'd1) begin
            cur_col_d = 8'd0;
            cur_row_d = cur_row_q + 8'd1;
          end else begin
            cur_col_d = cur_col_q + 8'd1;
          end
        end
        ST_IDLE, ST_DONE: overflow_d = 1'b1;
        default:          state_d    = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Read path samples the array before this cycle's write lands, giving read-before-write.
  always_comb begin
    rd_valid_d = bus.rd_en;
    rd_data_d  = rd_data_q;
    if (bus.rd_en) begin
      if (32'(bus.rd_addr) < 32'(DEPTH)) begin
        rd_data_d = rd_format(mem_q[bus.rd_addr[MEM_AW-1:0]]);
      end else begin
        rd_data_d = {DATA_W{1'b0}};
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      width_q        <= 8'd0;
      height_q       <= 8'd0;
      overflow_q     <= 1'b0;
      cfg_err_q      <= 1'b0;
      sample_count_q <= '0;
      cur_row_q      <= 8'd0;
      cur_col_q      <= 8'd0;
      rd_data_q      <= {DATA_W{1'b0}};
      rd_valid_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      width_q        <= width_d;
      height_q       <= height_d;
      overflow_q     <= overflow_d;
      cfg_err_q      <= cfg_err_d;
      sample_count_q <= sample_count_d;
      cur_row_q      <= cur_row_d;
      cur_col_q      <= cur_col_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
    end
  end

  // Frame buffer storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s[MEM_AW-1:0]] <= bus.din;
    end
  end

  assign bus.busy         = (state_q == ST_COLLECT);
  assign bus.frame_done   = (state_q == ST_DONE);
  assign bus.overflow     = overflow_q;
  assign bus.cfg_err      = cfg_err_q;
  assign bus.sample_count = sample_count_q;
  assign bus.cur_row      = cur_row_q;
  assign bus.cur_col      = cur_col_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
endmodule

// File: tb/tb_fmap_collector.sv
// Directed bench for fmap_collector: status checks inline, read data through a scoreboard queue.
module tb_fmap_collector;
  localparam int DATA_W  = 8;
  localparam int MAX_DIM = 16;
  localparam int ADDR_W  = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fmap_collector_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) fif ();

  fmap_collector #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(fif)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  function automatic logic [7:0] pix(input int v);
    logic [7:0] raw;
    raw = 8'(v);
`ifdef FMAP_UINT8_OUT_EN
    return raw + 8'd128;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input int w, input int h);
    fif.start     = 1'b1;
    fif.fm_width  = 8'(w);
    fif.fm_height = 8'(h);
    tick();
    fif.start = 1'b0;
  endtask

  task automatic send(input int v);
    fif.valid_in = 1'b1;
    fif.din      = 8'(v);
    tick();
    fif.valid_in = 1'b0;
  endtask

  task automatic rd(input int a, input logic [7:0] e);
    fif.rd_en   = 1'b1;
    fif.rd_addr = 9'(a);
    exp_q.push_back(e);
    tick();
    fif.rd_en = 1'b0;
  endtask

  // Read-data monitor: every rd_valid consumes one expected value.
  always @(negedge clk) begin
    if (!rst && fif.rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got rd_data=%0d with no read pending", fif.rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fif.rd_data !== mon_exp) begin
          failures++;
          $display("FAIL rd_data: got %0d expected %0d", fif.rd_data, mon_exp);
        end
      end
    end
  end

  initial begin
    fif.start = 1'b0; fif.fm_width = 8'd0; fif.fm_height = 8'd0;
    fif.valid_in = 1'b0; fif.din = 8'd0; fif.rd_en = 1'b0; fif.rd_addr = 9'd0;
    rst = 1'b1;
    tick(); tick();
    check("rst_busy", 32'(fif.busy), 0);
    check("rst_frame_done", 32'(fif.frame_done), 0);
    check("rst_overflow", 32'(fif.overflow), 0);
    check("rst_cfg_err", 32'(fif.cfg_err), 0);
    check("rst_count", 32'(fif.sample_count), 0);
    check("rst_rd_valid", 32'(fif.rd_valid), 0);
    check("rst_rd_data", 32'(fif.rd_data), 0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(fif.busy), 0);

    // 6x6 frame, three samples on then one idle cycle
    do_start(6, 6);
    check("f6_busy", 32'(fif.busy), 1);
    check("f6_count0", 32'(fif.sample_count), 0);
    for (int k = 0; k < 36; k++) begin
      fif.valid_in = 1'b1;
      fif.din      = 8'(k - 18);
      tick();
      if (k == 35) begin
        check("f6_done", 32'(fif.frame_done), 1);
        check("f6_count", 32'(fif.sample_count), 36);
        check("f6_busy_end", 32'(fif.busy), 0);
        check("f6_row_hold", 32'(fif.cur_row), 0);
        check("f6_col_hold", 32'(fif.cur_col), 0);
      end
      if (k % 3 == 2) begin
        fif.valid_in = 1'b0;
        tick();
      end
    end
    rd(0, pix(-18));
    rd(35, pix(17));
    tick();
    check("rd_hold_valid", 32'(fif.rd_valid), 0);
    check("rd_hold_data", 32'(fif.rd_data), 32'(pix(17)));

    // 37th sample after completion
    send(99);
    check("ovf_set", 32'(fif.overflow), 1);
    check("ovf_still_done", 32'(fif.frame_done), 1);
    rd(0, pix(-18));

    // 3x2 back-to-back wrap
    do_start(3, 2);
    check("ovf_cleared", 32'(fif.overflow), 0);
    fif.valid_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("wrap_col", 32'(fif.cur_col), 32'(k % 3));
      fif.din = 8'(10 + k);
      tick();
      if (k == 2) check("wrap_row", 32'(fif.cur_row), 1);
    end
    fif.valid_in = 1'b0;
    check("wrap_done", 32'(fif.frame_done), 1);
    rd(4, pix(14));

    // illegal configurations, then a legal one
    do_start(0, 4);
    check("cfg_w0_err", 32'(fif.cfg_err), 1);
    check("cfg_w0_idle", 32'({fif.busy, fif.frame_done}), 0);
    check("cfg_w0_ovf", 32'(fif.overflow), 0);
    do_start(17, 4);
    check("cfg_w17_err", 32'(fif.cfg_err), 1);
    check("cfg_w17_idle", 32'({fif.busy, fif.frame_done}), 0);
    do_start(4, 4);
    check("cfg_ok_clear", 32'(fif.cfg_err), 0);
    check("cfg_ok_busy", 32'(fif.busy), 1);

    // abort with start coincident with sample 10
    do_start(6, 6);
    for (int k = 0; k < 9; k++) send(50 + k);
    fif.valid_in = 1'b1; fif.din = 8'd77;
    do_start(6, 6);
    fif.valid_in = 1'b0;
    check("abort_count", 32'(fif.sample_count), 0);
    check("abort_busy", 32'(fif.busy), 1);
    check("abort_ovf", 32'(fif.overflow), 0);
    rd(8, pix(58));
    rd(9, pix(-9));

    // read-before-write hazard at address 5
    for (int k = 0; k < 6; k++) send((k == 5) ? -7 : 60 + k);
    do_start(6, 6);
    for (int k = 0; k < 5; k++) send(70 + k);
    fif.valid_in = 1'b1; fif.din = 8'd42;
    rd(5, pix(-7));
    fif.valid_in = 1'b0;
    rd(5, pix(42));
    rd(300, 8'd0);
    rd(1, pix(71));
    tick();
    check("pre_rst_count", 32'(fif.sample_count), 6);

    // asynchronous reset mid-frame
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(fif.busy), 0);
    check("arst_count", 32'(fif.sample_count), 0);
    check("arst_col", 32'(fif.cur_col), 0);
    check("arst_rd_data", 32'(fif.rd_data), 0);
    check("arst_flags", 32'({fif.frame_done, fif.overflow, fif.cfg_err, fif.rd_valid}), 0);
    tick();
    rst = 1'b0;
    tick();
    send(5);
    check("idle_sample_ovf", 32'(fif.overflow), 1);
    check("idle_sample_count", 32'(fif.sample_count), 0);

    tick(); tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
